// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer.
// State encoding, register width and control bundles.
package hazard_pkg;

  localparam int REG_W = 3;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_freeze;
    logic mem_error;
  } ctrl_t;

  // CTRL_NOP is the no-hazard control word: everything advances.
  localparam ctrl_t CTRL_NOP    = 6'b110000;
  localparam ctrl_t CTRL_LOAD   = 6'b000100;
  localparam ctrl_t CTRL_FREEZE = 6'b000010;
  localparam ctrl_t CTRL_BRANCH = 6'b111100;
  localparam ctrl_t CTRL_FLUSH  = 6'b111000;
  localparam ctrl_t CTRL_ABORT  = 6'b110001;

  function automatic logic is_load_use(
    input logic mem_read,
    input reg_t rd,
    input reg_t rs,
    input reg_t rt,
    input logic uses_rt
  );
    return mem_read && (rd != '0) &&
           ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with enable.
// Holds at all-ones; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use bubbles, branch flush,
// and memory freeze with watchdog abort.
module hazard_control_unit #(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT         = 255,
  parameter int CNT_W               = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       Ifid_rs,
  input  logic [2:0]       Ifid_rt,
  input  logic             Ifid_uses_rt,
  input  logic [2:0]       Idex_rd,
  input  logic             Idex_mem_read,
  input  logic             Branch_taken,
  input  logic             Jump_id,
  input  logic             Mem_req,
  input  logic             Mem_ready,
  output logic             Pc_write,
  output logic             Ifid_write,
  output logic             Ifid_flush,
  output logic             Idex_bubble,
  output logic             Pipe_freeze,
  output logic             Mem_error,
  output logic [CNT_W-1:0] Stall_count
);

  import hazard_pkg::*;

  localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FL_INIT = 2'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  localparam bit LS_MULTI = LOAD_STALL_CYCLES > 1;
  localparam bit FL_MULTI = BRANCH_FLUSH_CYCLES > 1;

  state_e     state_q, state_d;
  logic [1:0] ls_q, ls_d;
  logic [1:0] fl_q, fl_d;
  logic [7:0] wait_q, wait_d;
  ctrl_t      ctrl;

  logic load_use, mem_stall;
  logic ev_mem, ev_br, ev_lu, ev_jmp;

  always_comb begin
    load_use  = is_load_use(Idex_mem_read, Idex_rd,
                            Ifid_rs, Ifid_rt, Ifid_uses_rt);
    mem_stall = Mem_req && !Mem_ready;
    // Flatten the priority chain into one-hot events.
    ev_mem = mem_stall;
    ev_br  = Branch_taken && !ev_mem;
    ev_lu  = load_use && !Branch_taken && !ev_mem;
    ev_jmp = Jump_id && !load_use &&
             !Branch_taken && !ev_mem;
  end

  always_comb begin
    state_d = state_q;
    ls_d    = ls_q;
    fl_d    = fl_q;
    wait_d  = wait_q;
    ctrl    = CTRL_NOP;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          ev_mem: begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = 8'd1;
          end
          ev_br: begin
            ctrl = CTRL_BRANCH;
            if (FL_MULTI) begin
              state_d = FLUSH;
              fl_d    = FL_INIT;
            end
          end
          ev_lu: begin
            ctrl = CTRL_LOAD;
            if (LS_MULTI) begin
              state_d = LOAD_STALL;
              ls_d    = LS_INIT;
            end
          end
          ev_jmp: ctrl = CTRL_FLUSH;
          default: ;
        endcase
      end
      LOAD_STALL: begin
        unique case (1'b1)
          ev_mem: begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = 8'd1;
            ls_d    = '0;
          end
          ev_br: begin
            ctrl    = CTRL_BRANCH;
            ls_d    = '0;
            state_d = FL_MULTI ? FLUSH : RUN;
            fl_d    = FL_INIT;
          end
          default: begin
            ctrl = CTRL_LOAD;
            ls_d = ls_q - 2'd1;
            if (ls_q == 2'd1) state_d = RUN;
          end
        endcase
      end
      FLUSH: begin
        unique case (1'b1)
          ev_mem: begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = 8'd1;
            fl_d    = '0;
          end
          ev_br: begin
            ctrl = CTRL_BRANCH;
            fl_d = FL_INIT;
          end
          default: begin
            ctrl = CTRL_FLUSH;
            fl_d = fl_q - 2'd1;
            if (fl_q == 2'd1) state_d = RUN;
          end
        endcase
      end
      MEM_WAIT: begin
        if (Mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == TIMEOUT) begin
          ctrl    = CTRL_ABORT;
          state_d = RUN;
          wait_d  = '0;
        end else begin
          ctrl   = CTRL_FREEZE;
          wait_d = wait_q + 8'd1;
        end
      end
    endcase
    // No stray flush or bubble may leak out while reset is held.
    if (!Rst_n) ctrl = CTRL_NOP;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= RUN;
      ls_q    <= '0;
      fl_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ls_q    <= ls_d;
      fl_q    <= fl_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (Clk),
    .rst_n(Rst_n),
    .en   (!ctrl.pc_write),
    .count(Stall_count)
  );

  assign Pc_write    = ctrl.pc_write;
  assign Ifid_write  = ctrl.ifid_write;
  assign Ifid_flush  = ctrl.ifid_flush;
  assign Idex_bubble = ctrl.idex_bubble;
  assign Pipe_freeze = ctrl.pipe_freeze;
  assign Mem_error   = ctrl.mem_error;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit.
// Four parameterisations share one stimulus stream.
module tb_hazard_control_unit;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] Ifid_rs = '0, Ifid_rt = '0, Idex_rd = '0;
  logic       Ifid_uses_rt = 0, Idex_mem_read = 0;
  logic       Branch_taken = 0, Jump_id = 0;
  logic       Mem_req = 0, Mem_ready = 0;

  logic pw[4], iw[4], fl[4], bb[4], fz[4], me[4];
  logic [15:0] sc0, sc1, sc2;
  logic [1:0]  sc3;

  always #5 Clk = ~Clk;

  hazard_control_unit u_def (
    .Clk(Clk), .Rst_n(Rst_n),
    .Ifid_rs(Ifid_rs), .Ifid_rt(Ifid_rt),
    .Ifid_uses_rt(Ifid_uses_rt), .Idex_rd(Idex_rd),
    .Idex_mem_read(Idex_mem_read),
    .Branch_taken(Branch_taken), .Jump_id(Jump_id),
    .Mem_req(Mem_req), .Mem_ready(Mem_ready),
    .Pc_write(pw[0]), .Ifid_write(iw[0]),
    .Ifid_flush(fl[0]), .Idex_bubble(bb[0]),
    .Pipe_freeze(fz[0]), .Mem_error(me[0]),
    .Stall_count(sc0)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(2)) u_ls2 (
    .Clk(Clk), .Rst_n(Rst_n),
    .Ifid_rs(Ifid_rs), .Ifid_rt(Ifid_rt),
    .Ifid_uses_rt(Ifid_uses_rt), .Idex_rd(Idex_rd),
    .Idex_mem_read(Idex_mem_read),
    .Branch_taken(Branch_taken), .Jump_id(Jump_id),
    .Mem_req(Mem_req), .Mem_ready(Mem_ready),
    .Pc_write(pw[1]), .Ifid_write(iw[1]),
    .Ifid_flush(fl[1]), .Idex_bubble(bb[1]),
    .Pipe_freeze(fz[1]), .Mem_error(me[1]),
    .Stall_count(sc1)
  );

  hazard_control_unit #(.MEM_TIMEOUT(3)) u_to3 (
    .Clk(Clk), .Rst_n(Rst_n),
    .Ifid_rs(Ifid_rs), .Ifid_rt(Ifid_rt),
    .Ifid_uses_rt(Ifid_uses_rt), .Idex_rd(Idex_rd),
    .Idex_mem_read(Idex_mem_read),
    .Branch_taken(Branch_taken), .Jump_id(Jump_id),
    .Mem_req(Mem_req), .Mem_ready(Mem_ready),
    .Pc_write(pw[2]), .Ifid_write(iw[2]),
    .Ifid_flush(fl[2]), .Idex_bubble(bb[2]),
    .Pipe_freeze(fz[2]), .Mem_error(me[2]),
    .Stall_count(sc2)
  );

  hazard_control_unit #(.CNT_W(2)) u_c2 (
    .Clk(Clk), .Rst_n(Rst_n),
    .Ifid_rs(Ifid_rs), .Ifid_rt(Ifid_rt),
    .Ifid_uses_rt(Ifid_uses_rt), .Idex_rd(Idex_rd),
    .Idex_mem_read(Idex_mem_read),
    .Branch_taken(Branch_taken), .Jump_id(Jump_id),
    .Mem_req(Mem_req), .Mem_ready(Mem_ready),
    .Pc_write(pw[3]), .Ifid_write(iw[3]),
    .Ifid_flush(fl[3]), .Idex_bubble(bb[3]),
    .Pipe_freeze(fz[3]), .Mem_error(me[3]),
    .Stall_count(sc3)
  );

  // {pc_write, ifid_write, ifid_flush, bubble, freeze, error}
  localparam logic [5:0] E_RUN = 6'b110000;
  localparam logic [5:0] E_LU  = 6'b000100;
  localparam logic [5:0] E_BR  = 6'b111100;
  localparam logic [5:0] E_FL  = 6'b111000;
  localparam logic [5:0] E_MW  = 6'b000010;
  localparam logic [5:0] E_ERR = 6'b110001;

  // {rst, rs, rt, uses_rt, rd, mem_read, br, jmp, mreq, mrdy}
  localparam logic [15:0] RST  = 16'h8000;
  localparam logic [15:0] MR   = 16'h0010;
  localparam logic [15:0] BR   = 16'h0008;
  localparam logic [15:0] JMP  = 16'h0004;
  localparam logic [15:0] MREQ = 16'h0002;
  localparam logic [15:0] MRDY = 16'h0001;
  localparam logic [15:0] IDLE = 16'h0000;

  typedef struct {
    int         sel;
    logic [5:0] ctrl;
    int         cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  logic [5:0] act;
  int act_cnt;

  function automatic logic [15:0] regs(
    input int rs, input int rt,
    input int urt, input int rd
  );
    logic [15:0] r;
    r = '0;
    r[14:12] = 3'(rs);
    r[11:9]  = 3'(rt);
    r[8]     = 1'(urt);
    r[7:5]   = 3'(rd);
    return r;
  endfunction

  task automatic vec(
    input int sel, input logic [15:0] in,
    input logic [5:0] ex, input int cnt,
    input string nm
  );
    @(posedge Clk);
    #1;
    Ifid_rs       = in[14:12];
    Ifid_rt       = in[11:9];
    Ifid_uses_rt  = in[8];
    Idex_rd       = in[7:5];
    Idex_mem_read = in[4];
    Branch_taken  = in[3];
    Jump_id       = in[2];
    Mem_req       = in[1];
    Mem_ready     = in[0];
    if (!in[15]) Rst_n = 1'b1;
    q.push_back('{sel, ex, cnt, nm});
    if (in[15]) begin
      #2;
      Rst_n = 1'b0;
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {pw[e.sel], iw[e.sel], fl[e.sel],
             bb[e.sel], fz[e.sel], me[e.sel]};
      case (e.sel)
        0:       act_cnt = int'(sc0);
        1:       act_cnt = int'(sc1);
        2:       act_cnt = int'(sc2);
        default: act_cnt = int'(sc3);
      endcase
      checks++;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL %s ctrl got %b want %b",
                 e.nm, act, e.ctrl);
      end
      checks++;
      if (act_cnt != e.cnt) begin
        failures++;
        $display("FAIL %s stall_count got %0d want %0d",
                 e.nm, act_cnt, e.cnt);
      end
    end
  end

  initial begin
    logic [15:0] lu3;
    lu3 = regs(3, 0, 0, 3) | MR;

    vec(0, RST, E_RUN, 0, "a_reset");
    vec(0, IDLE, E_RUN, 0, "a_idle");
    vec(0, lu3, E_LU, 0, "a_lu_rs");
    vec(0, IDLE, E_RUN, 1, "a_lu_done");
    vec(0, regs(0, 0, 0, 0) | MR, E_RUN, 1, "a_r0");
    vec(0, regs(1, 5, 0, 5) | MR, E_RUN, 1, "a_rt_unused");
    vec(0, regs(1, 5, 1, 5) | MR, E_LU, 1, "a_lu_rt");
    vec(0, IDLE, E_RUN, 2, "a_lu_rt_done");
    vec(0, BR, E_BR, 2, "a_br0");
    vec(0, lu3, E_FL, 2, "a_br1_lu_ign");
    vec(0, IDLE, E_RUN, 2, "a_br2");
    vec(0, BR | lu3, E_BR, 2, "a_br_vs_lu");
    vec(0, IDLE, E_FL, 2, "a_br_vs_lu1");
    vec(0, JMP, E_FL, 2, "a_jmp");
    vec(0, IDLE, E_RUN, 2, "a_jmp_done");
    vec(0, JMP | lu3, E_LU, 2, "a_lu_vs_jmp");
    vec(0, IDLE, E_RUN, 3, "a_lu_vs_jmp1");
    vec(0, MREQ, E_MW, 3, "a_mw0");
    vec(0, MREQ, E_MW, 4, "a_mw1");
    vec(0, MREQ | BR | lu3, E_MW, 5, "a_mw2_ign");
    vec(0, MREQ, E_MW, 6, "a_mw3");
    vec(0, MREQ | MRDY, E_RUN, 7, "a_mw_ready");
    vec(0, IDLE, E_RUN, 7, "a_mw_after");
    vec(0, MREQ | BR, E_MW, 7, "a_mem_vs_br");
    vec(0, MREQ | MRDY, E_RUN, 8, "a_mem_vs_br1");
    vec(0, IDLE, E_RUN, 8, "a_idle2");
    vec(0, MREQ, E_MW, 8, "a_mw_pre_rst");
    vec(0, RST | MREQ | BR, E_RUN, 0, "a_rst_mid");
    vec(0, IDLE, E_RUN, 0, "a_post_rst");

    vec(1, RST, E_RUN, 0, "b_reset");
    vec(1, lu3, E_LU, 0, "b_lu0");
    vec(1, IDLE, E_LU, 1, "b_lu1");
    vec(1, IDLE, E_RUN, 2, "b_lu_done");
    vec(1, lu3, E_LU, 2, "b_lu_again");
    vec(1, BR, E_BR, 3, "b_br_in_ls");
    vec(1, IDLE, E_FL, 3, "b_flush");
    vec(1, IDLE, E_RUN, 3, "b_run");

    vec(2, RST, E_RUN, 0, "c_reset");
    vec(2, MREQ, E_MW, 0, "c_mw0");
    vec(2, MREQ, E_MW, 1, "c_mw1");
    vec(2, MREQ, E_MW, 2, "c_mw2");
    vec(2, MREQ, E_ERR, 3, "c_timeout");
    vec(2, IDLE, E_RUN, 3, "c_after");

    vec(3, RST, E_RUN, 0, "d_reset");
    vec(3, MREQ, E_MW, 0, "d_sat0");
    vec(3, MREQ, E_MW, 1, "d_sat1");
    vec(3, MREQ, E_MW, 2, "d_sat2");
    vec(3, MREQ, E_MW, 3, "d_sat3");
    vec(3, MREQ, E_MW, 3, "d_sat_hold");
    vec(3, MREQ | MRDY, E_RUN, 3, "d_release");

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
